ofm_tile_addr_gen: RTL and testbench
====================================

# ofm_tile_addr_gen

Parametrised output-feature-map write address generator for the systolic array datapath. It generalises the fixed-size OFM address controller. Runtime OFM width, filter count and base address are programmed per layer. Rows are walked in SYSTOLIC_SIZE-wide segments with a partial-segment `size` at the row edge. Each address is handed to the OFM buffer writer over a valid/ready handshake, and a done pulse marks the end of the layer.

## Interface
Parameters:
- ADDR_WIDTH, 22, OFM address width.
- SYSTOLIC_SIZE, 16, maximum pixels per write beat (array width).
- OFM_SIZE_MAX, 256, largest supported OFM side length.
- FILTER_MAX, 1024, largest supported filter (output channel) count.
- Derived: SZ_W = $clog2(OFM_SIZE_MAX+1), F_W = $clog2(FILTER_MAX+1), BEAT_W = $clog2(SYSTOLIC_SIZE+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; latches cfg_* when idle.
- cfg_ofm_size  in  SZ_W  OFM side length (square map).
- cfg_num_filter  in  F_W  number of output channels.
- cfg_base_addr  in  ADDR_WIDTH  address of pixel (0,0) of filter 0.
- wr_ready  in  1  writer accepts the current beat.
- wr_valid  out  1  beat valid.
- ofm_addr  out  ADDR_WIDTH  address of the first pixel of the beat.
- size  out  BEAT_W  valid pixels in the beat, 1..SYSTOLIC_SIZE.
- filter_idx  out  F_W  filter owning the beat.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Storage order is filter-major, then row, then column: addr = base + (f*N + r)*N + c, with N = cfg_ofm_size.
- No multiplier is used. A linear row pointer starts at base and gets +N per row, including across filter boundaries. A column offset gets +SYSTOLIC_SIZE per beat. ofm_addr = row_ptr + col.
- size = min(SYSTOLIC_SIZE, N − col).
- Traversal order: col (inner), row, filter (outer).
- States:
  - IDLE: start latches cfg_*, clears counters, moves to RUN.
  - RUN: wr_valid = 1. A beat is accepted on wr_valid & wr_ready.
  - On the last beat (f = F−1, r = N−1, col + SYSTOLIC_SIZE ≥ N), accept moves to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- start in RUN or DONE is ignored. Latched config cannot change mid-layer.
- Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently, except as described under Configuration.
- cfg_ofm_size = 0 or cfg_num_filter = 0, without the macro: RUN is skipped. DONE is entered directly, giving a done pulse two cycles after start with no beats.

## Timing
- Reset (rst_n = 0 at a clock edge): state IDLE. wr_valid, busy, done, ofm_addr, size, filter_idx and counters all go to 0. Reset in any state aborts the layer; no done pulse.
- All outputs are registered.
- Start at cycle T: wr_valid = 1 with ofm_addr = base at T+1.
- With wr_ready held high: one beat per cycle, no bubbles, including across row and filter boundaries.
- wr_valid low with wr_ready high: nothing advances. wr_valid high with wr_ready low: ofm_addr, size and filter_idx stay stable; wr_valid is never dropped.
- Last beat accepted at cycle L: wr_valid = 0 and done = 1 at L+1; busy = 0 at L+2.
- A start at L+2 begins the next layer, giving back-to-back layers with a 2-cycle gap.

## Configuration
- OFM_ADDR_ERR_EN defined:
  - Adds output port err (1 bit, reset 0).
  - When start is taken with N = 0, F = 0, N > OFM_SIZE_MAX, F > FILTER_MAX, or base + F*N*N − 1 ≥ 2^ADDR_WIDTH, the block sets err = 1, stays IDLE, and emits no beats and no done.
  - err clears on the next accepted start with legal config, or on reset.
- Not defined: no err port, no checks. Zero config follows the direct-to-DONE path; overflowing addresses wrap.

## Test plan
- N=32, F=2, base=0, wr_ready=1: 128 beats; addrs 0,16,32,…,2032; size=16 throughout; filter_idx steps to 1 at beat 65 (addr 1024); done one cycle after beat 128.
- N=20, F=1, base=0x100: beat pairs per row, (0x100, 16), (0x110, 4), then (0x114, 16), (0x124, 4), …; 40 beats total; last beat is (0x100+396, 4).
- N=13, F=3, base=0: one beat per row, size=13; addrs step by 13; last addr 494; filter_idx = 0,1,2.
- Backpressure: N=32, F=1, wr_ready low for 3 cycles at beat 5. ofm_addr=64 and size=16 held stable and wr_valid stays high; the sequence resumes at addr 80 with no skipped or duplicated beat.
- Control: a start pulsed during RUN is ignored (no restart). rst_n=0 for one cycle at beat 10 gives all outputs 0 and no done. A new start then begins again at base.
- OFM_ADDR_ERR_EN: start with N=0 → err=1, wr_valid=0, no done. Start with N=256, F=1024, ADDR_WIDTH=22 → overflow, err=1. A legal start then clears err.

Source files
------------

// File: rtl/ofm_tile_addr_gen.sv
// ofm_tile_addr_gen: OFM write-address walker (col, row, filter order).
// Ports: clk, rst_n, start, cfg_ofm_size, cfg_num_filter, cfg_base_addr,
//   wr_ready in; wr_valid, ofm_addr, size, filter_idx, busy, done out.
//   Optional config check via OFM_ADDR_ERR_EN adds output err.
module ofm_tile_addr_gen #(
  parameter int ADDR_WIDTH    = 22,
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_SIZE_MAX  = 256,
  parameter int FILTER_MAX    = 1024,
  localparam int SZ_W   = $clog2(OFM_SIZE_MAX+1),
  localparam int F_W    = $clog2(FILTER_MAX+1),
  localparam int BEAT_W = $clog2(SYSTOLIC_SIZE+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SZ_W-1:0]       cfg_ofm_size,
  input  logic [F_W-1:0]        cfg_num_filter,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                  wr_ready,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] ofm_addr,
  output logic [BEAT_W-1:0]     size,
  output logic [F_W-1:0]        filter_idx,
  output logic                  busy,
  output logic                  done
`ifdef OFM_ADDR_ERR_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [SZ_W:0] SS = (SZ_W+1)'(SYSTOLIC_SIZE);

  state_t                r_state, w_state_nxt;
  logic [SZ_W-1:0]       r_n, w_n;
  logic [F_W-1:0]        r_f, w_f;
  logic [ADDR_WIDTH-1:0] r_rowptr, w_rowptr;
  logic [SZ_W-1:0]       r_col, w_col;
  logic [SZ_W-1:0]       r_row, w_row;
  logic [F_W-1:0]        r_fil, w_fil;
  logic                  r_skip, w_skip;
  logic                  r_valid, w_valid;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [BEAT_W-1:0]     r_size, w_size;
  logic [F_W-1:0]        r_fidx, w_fidx;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;

  logic [SZ_W:0]         w_cs;
  logic                  w_wrap;
  logic                  w_last;
  logic                  w_zero;
  logic                  w_go;
  logic                  w_skip_go;

  function automatic logic [BEAT_W-1:0] f_size(input logic [SZ_W-1:0] rem);
    return ({1'b0, rem} < SS) ? BEAT_W'(rem) : BEAT_W'(SYSTOLIC_SIZE);
  endfunction

  assign w_zero = (cfg_ofm_size == '0) || (cfg_num_filter == '0);
  assign w_cs   = {1'b0, r_col} + SS;
  assign w_wrap = (w_cs >= {1'b0, r_n});
  assign w_last = w_wrap
               && (r_row == r_n - 1'b1)
               && (r_fil == r_f - 1'b1);

`ifdef OFM_ADDR_ERR_EN
  localparam int PW = ADDR_WIDTH + F_W + 2*SZ_W + 1;

  logic          r_err, w_err;
  logic          w_bad;
  logic [PW-1:0] w_span;

  // Last address is base + F*N*N - 1; it must fit below 2^ADDR_WIDTH.
  assign w_span = PW'(cfg_num_filter) * PW'(cfg_ofm_size)
                * PW'(cfg_ofm_size) + PW'(cfg_base_addr);
  assign w_bad  = w_zero
               || (cfg_ofm_size > SZ_W'(OFM_SIZE_MAX))
               || (cfg_num_filter > F_W'(FILTER_MAX))
               || (w_span > (PW'(1) << ADDR_WIDTH));
  assign w_go      = start & ~w_bad;
  assign w_skip_go = 1'b0;
  assign err       = r_err;

  always_comb begin
    w_err = r_err;
    if (r_state == S_IDLE && start) w_err = w_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_err;
  end
`else
  // Empty layer: no beats, but still a done pulse.
  assign w_go      = start & ~w_zero;
  assign w_skip_go = start & w_zero;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_n         = r_n;
    w_f         = r_f;
    w_rowptr    = r_rowptr;
    w_col       = r_col;
    w_row       = r_row;
    w_fil       = r_fil;
    w_skip      = r_skip;
    w_valid     = r_valid;
    w_addr      = r_addr;
    w_size      = r_size;
    w_fidx      = r_fidx;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt = S_RUN;
          w_n         = cfg_ofm_size;
          w_f         = cfg_num_filter;
          w_rowptr    = cfg_base_addr;
          w_col       = '0;
          w_row       = '0;
          w_fil       = '0;
          w_valid     = 1'b1;
          w_addr      = cfg_base_addr;
          w_size      = f_size(cfg_ofm_size);
          w_fidx      = '0;
        end else if (w_skip_go) begin
          w_state_nxt = S_DONE;
          w_skip      = 1'b1;
        end
      end
      S_RUN: begin
        if (r_valid && wr_ready) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_valid     = 1'b0;
            w_done      = 1'b1;
          end else begin
            if (!w_wrap) begin
              w_col = w_cs[SZ_W-1:0];
            end else begin
              w_col    = '0;
              // Row pointer strides by N straight across filter edges.
              w_rowptr = r_rowptr + ADDR_WIDTH'(r_n);
              if (r_row == r_n - 1'b1) begin
                w_row = '0;
                w_fil = r_fil + 1'b1;
              end else begin
                w_row = r_row + 1'b1;
              end
            end
            w_addr = w_rowptr + ADDR_WIDTH'(w_col);
            w_size = f_size(r_n - w_col);
            w_fidx = w_fil;
          end
        end
      end
      S_DONE: begin
        // Skip path spends one extra DONE cycle so done lands at start+2.
        if (r_skip) begin
          w_skip = 1'b0;
          w_done = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_f      <= '0;
      r_rowptr <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_fil    <= '0;
      r_skip   <= 1'b0;
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_size   <= '0;
      r_fidx   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_n      <= w_n;
      r_f      <= w_f;
      r_rowptr <= w_rowptr;
      r_col    <= w_col;
      r_row    <= w_row;
      r_fil    <= w_fil;
      r_skip   <= w_skip;
      r_valid  <= w_valid;
      r_addr   <= w_addr;
      r_size   <= w_size;
      r_fidx   <= w_fidx;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign wr_valid   = r_valid;
  assign ofm_addr   = r_addr;
  assign size       = r_size;
  assign filter_idx = r_fidx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_ofm_tile_addr_gen.sv
// tb_ofm_tile_addr_gen: directed bench for ofm_tile_addr_gen.
// Expected beats come from addr = base + (f*N + r)*N + c.
module tb_ofm_tile_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  cfg_ofm_size;
  logic [10:0] cfg_num_filter;
  logic [21:0] cfg_base_addr;
  logic        wr_ready;
  logic        wr_valid;
  logic [21:0] ofm_addr;
  logic [4:0]  size;
  logic [10:0] filter_idx;
  logic        busy;
  logic        done;
`ifdef OFM_ADDR_ERR_EN
  logic        err;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ofm_tile_addr_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_ofm_size   (cfg_ofm_size),
    .cfg_num_filter (cfg_num_filter),
    .cfg_base_addr  (cfg_base_addr),
    .wr_ready       (wr_ready),
    .wr_valid       (wr_valid),
    .ofm_addr       (ofm_addr),
    .size           (size),
    .filter_idx     (filter_idx),
    .busy           (busy),
`ifdef OFM_ADDR_ERR_EN
    .done           (done),
    .err            (err)
`else
    .done           (done)
`endif
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n, input int f,
                             input logic [21:0] base);
    cfg_ofm_size   = 9'(n);
    cfg_num_filter = 11'(f);
    cfg_base_addr  = base;
    start          = 1'b1;
    tick();
    start          = 1'b0;
    // Scramble cfg to show the layer uses latched values.
    cfg_ofm_size   = 9'd5;
    cfg_num_filter = 11'd9;
    cfg_base_addr  = 22'h2AAAA;
  endtask

  task automatic run_layer(input int n, input int f,
                           input logic [21:0] base,
                           input int stall_at, input int stall_len,
                           input int poke_at, input int abort_at);
    int k;
    logic [21:0] ea;
    int es;
    k = 0;
    wr_ready = 1'b1;
    pulse_start(n, f, base);
    for (int fi = 0; fi < f; fi++) begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c += 16) begin
          ea = 22'(longint'(base) + longint'((fi*n + r)*n + c));
          es = (n - c < 16) ? n - c : 16;
          if (k == abort_at) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk("rst_valid", wr_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_addr", ofm_addr, 0);
            chk("rst_size", size, 0);
            chk("rst_fidx", filter_idx, 0);
            for (int i = 0; i < 4; i++) begin
              chk("rst_done", done, 0);
              tick();
            end
            return;
          end
          if (k == stall_at) begin
            wr_ready = 1'b0;
            for (int i = 0; i < stall_len; i++) begin
              tick();
              chk("stall_valid", wr_valid, 1);
              chk("stall_addr", ofm_addr, ea);
              chk("stall_size", size, es);
            end
            wr_ready = 1'b1;
          end
          chk("valid", wr_valid, 1);
          chk("addr", ofm_addr, ea);
          chk("size", size, es);
          chk("fidx", filter_idx, fi);
          chk("nodone", done, 0);
          if (k == poke_at) begin
            cfg_ofm_size   = 9'd7;
            cfg_num_filter = 11'd1;
            cfg_base_addr  = 22'h3000;
            start          = 1'b1;
          end
          tick();
          start = 1'b0;
          k++;
        end
      end
    end
    chk("end_done", done, 1);
    chk("end_valid", wr_valid, 0);
    chk("end_busy", busy, 1);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    wr_ready       = 1'b0;
    cfg_ofm_size   = '0;
    cfg_num_filter = '0;
    cfg_base_addr  = '0;
    tick();
    tick();
    chk("reset_valid", wr_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_addr", ofm_addr, 0);
    chk("reset_size", size, 0);
    chk("reset_fidx", filter_idx, 0);
    rst_n = 1'b1;
    tick();

    run_layer(32, 2, 22'h0, -1, 0, -1, -1);
    // back-to-back, 2-cycle gap
    run_layer(20, 1, 22'h100, -1, 0, -1, -1);
    run_layer(13, 3, 22'h0, -1, 0, -1, -1);
    run_layer(32, 1, 22'h0, 4, 3, -1, -1);
    run_layer(32, 1, 22'h40, -1, 0, 3, 10);
    run_layer(13, 1, 22'h40, -1, 0, -1, -1);

`ifdef OFM_ADDR_ERR_EN
    pulse_start(0, 1, 22'h0);
    chk("err_zero", err, 1);
    chk("err_zero_valid", wr_valid, 0);
    chk("err_zero_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_zero_done", done, 0);
    end
    run_layer(13, 1, 22'h0, -1, 0, -1, -1);
    chk("err_clear1", err, 0);
    pulse_start(256, 1024, 22'h0);
    chk("err_ovf", err, 1);
    chk("err_ovf_valid", wr_valid, 0);
    tick();
    chk("err_ovf_done", done, 0);
    run_layer(20, 1, 22'h10, -1, 0, -1, -1);
    chk("err_clear2", err, 0);
`else
    pulse_start(0, 5, 22'h0);
    chk("zero_valid", wr_valid, 0);
    chk("zero_busy", busy, 1);
    chk("zero_done0", done, 0);
    tick();
    chk("zero_done1", done, 1);
    chk("zero_valid1", wr_valid, 0);
    tick();
    chk("zero_done2", done, 0);
    chk("zero_busy2", busy, 0);
    // address wrap at 2^22
    run_layer(4, 1, 22'h3FFFF8, -1, 0, -1, -1);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
